// File: rtl/starship_repair_combo_gen_if.sv
// Handshake bundle between the Starship top level and the breach/repair combo generator.
interface starship_repair_combo_gen_if;
  logic        play;
  logic        combo_valid;
  logic [3:0]  combo_in;
  logic [1:0]  room_sel;
  logic [3:0]  broken;
  logic [15:0] repair_combo;
  logic        repair_ok;
  logic        repair_fail;
  logic        game_over;

  modport master (
    output play, combo_valid, combo_in, room_sel,
    input  broken, repair_combo, repair_ok, repair_fail, game_over
  );

  modport slave (
    input  play, combo_valid, combo_in, room_sel,
    output broken, repair_combo, repair_ok, repair_fail, game_over
  );
endinterface

// File: rtl/starship_repair_combo_gen.sv
// Timed hull-breach generator for four rooms: issues a random repair nibble per breach,
// checks player entries and raises a sticky game_over when a room stays broken too long.
module starship_repair_combo_gen #(
  parameter int unsigned BREAK_INTERVAL = 100_000_000,
  parameter int unsigned REPAIR_TIMEOUT = 500_000_000,
  parameter logic [15:0] LFSR_SEED      = 16'hACE1
) (
  input  logic                        board_clk,
  input  logic                        Reset,
  starship_repair_combo_gen_if.slave  bus
);

  localparam logic [31:0] INT_LAST  = 32'(BREAK_INTERVAL - 1);
  localparam logic [31:0] TMR_LAST  = 32'(REPAIR_TIMEOUT - 1);
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  logic [15:0]      lfsr_q, lfsr_d;
  logic [31:0]      int_cnt_q, int_cnt_d;
  logic [3:0][31:0] timer_q, timer_d;
  logic [3:0]       broken_q, broken_d;
  logic [3:0][3:0]  combo_q, combo_d;
  logic             repair_ok_q, repair_ok_d;
  logic             repair_fail_q, repair_fail_d;
  logic             game_over_q, game_over_d;

  logic       run, breach, any_term, entry, hit;
  logic [1:0] cand;
  logic [3:0] term;

  always_comb begin
    run    = bus.play && !game_over_q;
    lfsr_d = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? LFSR_TAPS : 16'h0000);

    breach    = run && (int_cnt_q == INT_LAST);
    int_cnt_d = int_cnt_q;
    if (run) int_cnt_d = breach ? 32'd0 : int_cnt_q + 32'd1;

    for (int r = 0; r < 4; r++)
      term[r] = run && broken_q[r] && (timer_q[r] == TMR_LAST);
    any_term = |term;

    // A timer expiring this cycle ends the game, so the entry and any breach are discarded.
    entry = bus.combo_valid && run && !any_term;
    hit   = entry && broken_q[bus.room_sel] && (bus.combo_in == combo_q[bus.room_sel]);
    cand  = lfsr_q[1:0];

    broken_d = broken_q;
    combo_d  = combo_q;
    timer_d  = timer_q;
    for (int r = 0; r < 4; r++)
      if (run && broken_q[r]) timer_d[r] = timer_q[r] + 32'd1;

    if (hit) begin
      broken_d[bus.room_sel] = 1'b0;
      combo_d[bus.room_sel]  = 4'h0;
      timer_d[bus.room_sel]  = 32'd0;
    end

    // Candidate already broken (including one being repaired now) drops the attempt.
    if (breach && !any_term && !broken_q[cand]) begin
      broken_d[cand] = 1'b1;
      combo_d[cand]  = lfsr_q[7:4];
      timer_d[cand]  = 32'd0;
    end

    game_over_d   = game_over_q || any_term;
    repair_ok_d   = hit;
    repair_fail_d = entry && !hit;
  end

  always_ff @(posedge board_clk or posedge Reset) begin
    if (Reset) begin
      lfsr_q        <= LFSR_SEED;
      int_cnt_q     <= '0;
      timer_q       <= '0;
      broken_q      <= '0;
      combo_q       <= '0;
      repair_ok_q   <= 1'b0;
      repair_fail_q <= 1'b0;
      game_over_q   <= 1'b0;
    end else begin
      lfsr_q        <= lfsr_d;
      int_cnt_q     <= int_cnt_d;
      timer_q       <= timer_d;
      broken_q      <= broken_d;
      combo_q       <= combo_d;
      repair_ok_q   <= repair_ok_d;
      repair_fail_q <= repair_fail_d;
      game_over_q   <= game_over_d;
    end
  end

  assign bus.broken       = broken_q;
  assign bus.repair_combo = combo_q;
  assign bus.repair_ok    = repair_ok_q;
  assign bus.repair_fail  = repair_fail_q;
  assign bus.game_over    = game_over_q;

endmodule

// File: tb/tb_starship_repair_combo_gen.sv
// Directed bench for starship_repair_combo_gen with BREAK_INTERVAL=8, REPAIR_TIMEOUT=20.
module tb_starship_repair_combo_gen;

  logic board_clk = 1'b0;
  logic Reset     = 1'b1;
  int   checks    = 0;
  int   errors    = 0;

  int          cyc;
  logic [15:0] m_l;
  logic [3:0]  exp_brk;
  logic [15:0] exp_cmb;

  typedef struct {
    logic        v;
    logic [1:0]  sel;
    logic [3:0]  c;
    logic        ok;
    logic        fail;
    logic [3:0]  brk;
    logic [15:0] cmb;
  } vec_t;
  vec_t tbl [6];

  starship_repair_combo_gen_if bus_if();

  starship_repair_combo_gen #(
    .BREAK_INTERVAL(8),
    .REPAIR_TIMEOUT(20),
    .LFSR_SEED(16'hACE1)
  ) dut (
    .board_clk (board_clk),
    .Reset     (Reset),
    .bus       (bus_if)
  );

  always #5 board_clk = ~board_clk;

  // Reference Galois LFSR, x^16+x^14+x^13+x^11+1, shifting toward bit 0.
  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    logic [15:0] n;
    n = s >> 1;
    if (s[0]) begin
      n[15] = ~n[15];
      n[13] = ~n[13];
      n[12] = ~n[12];
      n[10] = ~n[10];
    end
    return n;
  endfunction

  // cyc == n and m_l == L_n right after the n-th edge since reset release.
  always @(posedge board_clk or posedge Reset) begin
    if (Reset) begin
      m_l <= 16'hACE1;
      cyc <= 0;
    end else begin
      m_l <= lfsr_next(m_l);
      cyc <= cyc + 1;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge board_clk);
    @(negedge board_clk);
  endtask

  task automatic run_to(input int n);
    int guard = 0;
    while (cyc < n && guard < 2000) begin
      tick();
      guard++;
    end
    chk($sformatf("run_to_%0d", n), cyc, n);
  endtask

  task automatic do_reset();
    Reset = 1'b1;
    bus_if.play = 1'b0;
    bus_if.combo_valid = 1'b0;
    bus_if.room_sel = 2'd0;
    bus_if.combo_in = 4'h0;
    tick();
    tick();
    chk("reset_outs", {bus_if.broken, bus_if.repair_combo, bus_if.repair_ok,
                       bus_if.repair_fail, bus_if.game_over}, 32'd0);
    Reset = 1'b0;
    exp_brk = 4'h0;
    exp_cmb = 16'h0;
  endtask

  task automatic enter(input logic [1:0] sel, input logic [3:0] c);
    bus_if.room_sel = sel;
    bus_if.combo_in = c;
    bus_if.combo_valid = 1'b1;
    tick();
    bus_if.combo_valid = 1'b0;
  endtask

  // Call with cyc == edge-1 so m_l holds the value the breach edge samples.
  task automatic breach_model();
    int r;
    r = int'(m_l[1:0]);
    if (!exp_brk[r]) begin
      exp_brk[r] = 1'b1;
      exp_cmb[4*r +: 4] = m_l[7:4];
    end
  endtask

  task automatic check_state(input string name);
    chk({name, "_brk"}, bus_if.broken, exp_brk);
    chk({name, "_cmb"}, bus_if.repair_combo, exp_cmb);
  endtask

  initial begin
    logic [1:0] go_room, r24;
    logic [3:0] go_cmb, n24;

    // First breach hits room 1 with combo 8 (L7 = 16'hED89).
    tbl[0] = '{1'b1, 2'd0, 4'h8, 1'b0, 1'b1, 4'b0010, 16'h0080};
    tbl[1] = '{1'b1, 2'd1, 4'h9, 1'b0, 1'b1, 4'b0010, 16'h0080};
    tbl[2] = '{1'b1, 2'd1, 4'h8, 1'b1, 1'b0, 4'b0000, 16'h0000};
    tbl[3] = '{1'b1, 2'd1, 4'h8, 1'b0, 1'b1, 4'b0000, 16'h0000};
    tbl[4] = '{1'b0, 2'd1, 4'h8, 1'b0, 1'b0, 4'b0000, 16'h0000};
    tbl[5] = '{1'b1, 2'd1, 4'h0, 1'b0, 1'b1, 4'b0000, 16'h0000};

    // First breach timing and content
    do_reset();
    bus_if.play = 1'b1;
    run_to(7);
    chk("t1_pre_brk", bus_if.broken, 4'h0);
    breach_model();
    tick();
    chk("t1_brk_hand", bus_if.broken, 4'b0010);
    chk("t1_cmb_hand", bus_if.repair_combo, 16'h0080);
    check_state("t1_model");

    // Entry vectors, back-to-back
    for (int i = 0; i < 6; i++) begin
      bus_if.room_sel = tbl[i].sel;
      bus_if.combo_in = tbl[i].c;
      bus_if.combo_valid = tbl[i].v;
      tick();
      bus_if.combo_valid = 1'b0;
      chk($sformatf("t2_v%0d_ok", i), bus_if.repair_ok, tbl[i].ok);
      chk($sformatf("t2_v%0d_fail", i), bus_if.repair_fail, tbl[i].fail);
      chk($sformatf("t2_v%0d_brk", i), bus_if.broken, tbl[i].brk);
      chk($sformatf("t2_v%0d_cmb", i), bus_if.repair_combo, tbl[i].cmb);
    end
    run_to(15);
    exp_brk = 4'h0;
    exp_cmb = 16'h0;
    go_room = m_l[1:0];
    go_cmb  = m_l[7:4];
    breach_model();
    tick();
    check_state("t2_rebreak");

    // Unrepaired room from edge 16 ends the game at edge 36
    run_to(23);
    breach_model();
    tick();
    check_state("t3_b24");
    run_to(31);
    breach_model();
    tick();
    check_state("t3_b32");
    run_to(35);
    chk("t3_go_pre", bus_if.game_over, 1'b0);
    tick();
    chk("t3_go", bus_if.game_over, 1'b1);
    check_state("t3_frozen");
    enter(go_room, go_cmb);
    chk("t3_no_ok", bus_if.repair_ok, 1'b0);
    chk("t3_no_fail", bus_if.repair_fail, 1'b0);
    repeat (10) tick();
    check_state("t3_after");
    chk("t3_go_sticky", bus_if.game_over, 1'b1);

    // play low for 50 cycles shifts breach and game_over by 50
    do_reset();
    bus_if.play = 1'b1;
    run_to(5);
    bus_if.play = 1'b0;
    run_to(8);
    chk("t4_hold_brk", bus_if.broken, 4'h0);
    run_to(55);
    bus_if.play = 1'b1;
    run_to(57);
    chk("t4_pre_brk", bus_if.broken, 4'h0);
    breach_model();
    tick();
    check_state("t4_b58");
    run_to(68);
    bus_if.play = 1'b0;
    run_to(118);
    bus_if.play = 1'b1;
    run_to(127);
    chk("t4_go_pre", bus_if.game_over, 1'b0);
    tick();
    chk("t4_go", bus_if.game_over, 1'b1);

    // Repair collides with a breach on the same room (L15 targets room 1)
    do_reset();
    bus_if.play = 1'b1;
    run_to(15);
    chk("t5_pre_brk", bus_if.broken, 4'b0010);
    enter(2'd1, 4'h8);
    chk("t5_ok", bus_if.repair_ok, 1'b1);
    chk("t5_brk", bus_if.broken, 4'h0);
    chk("t5_cmb", bus_if.repair_combo, 16'h0);
    // Correct entry at timer terminal
    run_to(23);
    exp_brk = 4'h0;
    exp_cmb = 16'h0;
    r24 = m_l[1:0];
    n24 = m_l[7:4];
    breach_model();
    tick();
    check_state("t5_b24");
    run_to(31);
    breach_model();
    tick();
    run_to(39);
    breach_model();
    tick();
    run_to(43);
    chk("t5_go_pre", bus_if.game_over, 1'b0);
    enter(r24, n24);
    chk("t5_go", bus_if.game_over, 1'b1);
    chk("t5_term_no_ok", bus_if.repair_ok, 1'b0);
    chk("t5_term_no_fail", bus_if.repair_fail, 1'b0);
    check_state("t5_term");

    // Reset with a repair_ok pulse in flight
    do_reset();
    bus_if.play = 1'b1;
    run_to(8);
    bus_if.room_sel = 2'd1;
    bus_if.combo_in = 4'h8;
    bus_if.combo_valid = 1'b1;
    @(posedge board_clk);
    #2;
    chk("t6_ok_inflight", bus_if.repair_ok, 1'b1);
    Reset = 1'b1;
    #1;
    chk("t6_async_clear", {bus_if.broken, bus_if.repair_combo, bus_if.repair_ok,
                           bus_if.repair_fail, bus_if.game_over}, 32'd0);
    bus_if.combo_valid = 1'b0;
    @(negedge board_clk);
    Reset = 1'b0;
    run_to(7);
    chk("t6_pre_brk", bus_if.broken, 4'h0);
    tick();
    chk("t6_brk", bus_if.broken, 4'b0010);
    chk("t6_cmb", bus_if.repair_combo, 16'h0080);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
